// File: rtl/clock_pkg.sv
// Shared definitions for the clock-domain utility blocks: meter state encoding
// and default counter width.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_HOLD    = 2'd3
  } meter_state_t;

  localparam int unsigned DEFAULT_CNT_W = 24;

endpackage

// File: rtl/sync_edge_detector.sv
// Synchronizes an asynchronous input and emits registered single-cycle rise/fall
// pulses, SYNC_STAGES+1 clk edges after the input transition.
module sync_edge_detector #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  // chain[SYNC_STAGES-1] is the synchronized level, chain[SYNC_STAGES] its previous value
  logic [SYNC_STAGES:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-1:0], d};
      rise  <= chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES];
      fall  <= ~chain[SYNC_STAGES-1] & chain[SYNC_STAGES];
    end
  end

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow input in clk cycles, results offered
// over valid/ready. Define PERIOD_METER_AVG_EN to report the average of four periods.
module period_meter
  import clock_pkg::*;
#(
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overflow,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  meter_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic             hi_seen;
  logic             rise;
  logic             fall;
  logic             sat_c;
  logic [CNT_W-1:0] hi_now_c;

`ifdef PERIOD_METER_AVG_EN
  localparam int unsigned SUM_W = CNT_W + 2;
  logic [SUM_W-1:0] sum;
  logic [1:0]       win;
  logic [SUM_W-1:0] sum_next_c;

  assign sum_next_c = sum + SUM_W'(cnt);
`endif

  sync_edge_detector #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sig_in),
    .rise    (rise),
    .fall    (fall)
  );

  assign sat_c = (cnt == CNT_MAX);
  // A fall in the saturating cycle still counts as the window's high time
  assign hi_now_c = hi_seen ? hi_cnt : (fall ? cnt : CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi_cnt    <= '0;
      hi_seen   <= 1'b0;
      period    <= '0;
      high_time <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
      sum       <= '0;
      win       <= '0;
`endif
    end else if (!meas_en) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi_seen   <= 1'b0;
      period    <= '0;
      high_time <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= 1'b1;
`ifdef PERIOD_METER_AVG_EN
      // Accumulator is only meaningful while chaining windows in MEASURE
      if (state != ST_MEASURE) begin
        sum <= '0;
        win <= '0;
      end
`endif
      case (state)
        ST_IDLE: begin
          cnt   <= '0;
          state <= ST_ARM;
        end
        ST_ARM: begin
          if (rise) begin
            cnt     <= CNT_ONE;
            hi_seen <= 1'b0;
            state   <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
`ifdef PERIOD_METER_AVG_EN
            if (win == 2'd3) begin
              period    <= CNT_W'(sum_next_c >> 2);
              high_time <= hi_now_c;
              overflow  <= 1'b0;
              valid     <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              // Intermediate edge closes one window and opens the next
              sum     <= sum_next_c;
              win     <= win + 2'd1;
              cnt     <= CNT_ONE;
              hi_seen <= 1'b0;
            end
`else
            period    <= cnt;
            high_time <= hi_now_c;
            overflow  <= 1'b0;
            valid     <= 1'b1;
            state     <= ST_HOLD;
`endif
          end else if (sat_c) begin
            period    <= CNT_MAX;
            high_time <= hi_now_c;
            overflow  <= 1'b1;
            valid     <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (fall && !hi_seen) begin
              hi_cnt  <= cnt;
              hi_seen <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // A rise coinciding with the accept starts the next window immediately
          if (valid && ready) begin
            valid   <= 1'b0;
            cnt     <= CNT_ONE;
            hi_seen <= 1'b0;
            state   <= rise ? ST_MEASURE : ST_ARM;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Randomized and directed bench for period_meter with an event-level reference
// model and a result scoreboard.
module tb_period_meter;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SYNC  = 2;
  localparam int LAT  = SYNC + 1;
  localparam int MAXV = (1 << CNT_W) - 1;
  localparam int MAXL = 12000;
`ifdef PERIOD_METER_AVG_EN
  localparam int NWIN = 4;
`else
  localparam int NWIN = 1;
`endif

  typedef struct {
    int per;
    int hi;
    bit ovf;
    int pres;
    int acc;
  } exp_t;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             sig_in  = 1'b0;
  logic             meas_en = 1'b0;
  logic             ready   = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             overflow;
  logic             valid;
  logic             busy;

  bit   sig_w [MAXL];
  bit   rdy_w [MAXL];
  int   L, en_start, pc;
  bit   in_phase;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fq[$];
  int   ph_hi[$];
  int   ph_lo[$];
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sig_in    (sig_in),
    .meas_en   (meas_en),
    .period    (period),
    .high_time (high_time),
    .overflow  (overflow),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int first_fall(input int lo, input int hi);
    for (int j = 0; j < fq.size(); j++)
      if (fq[j] > lo && fq[j] <= hi) return fq[j] - lo;
    return MAXV;
  endfunction

  task automatic add_period(input int hi, input int lo);
    ph_hi.push_back(hi);
    ph_lo.push_back(lo);
  endtask

  task automatic set_periods(input int hi, input int lo, input int n);
    ph_hi.delete();
    ph_lo.delete();
    for (int j = 0; j < n; j++) add_period(hi, lo);
  endtask

  // Waveform: `pre` low cycles, the listed periods, then a 20-cycle low tail
  task automatic build_wave(input int pre);
    for (int c = 0; c < MAXL; c++) begin
      sig_w[c] = 1'b0;
      rdy_w[c] = 1'b1;
    end
    L = pre;
    for (int j = 0; j < ph_hi.size(); j++) begin
      for (int k = 0; k < ph_hi[j]; k++) begin
        sig_w[L] = 1'b1;
        L++;
      end
      L += ph_lo[j];
    end
    L += 20;
    en_start = 0;
  endtask

  // Reference: windows between synchronized rises, results presented the cycle
  // after the window ends, next window starts at the first rise at/after accept.
  task automatic compute_model();
    int rq[$];
    int i, cur, endc, sum, hi, acc;
    bit ovf, done, prev;
    exp_t e;
    fq.delete();
    for (int c = 0; c < L; c++) begin
      prev = (c > 0) ? sig_w[c-1] : 1'b0;
      if (c + LAT < L) begin
        if (sig_w[c] && !prev) rq.push_back(c + LAT);
        if (!sig_w[c] && prev) fq.push_back(c + LAT);
      end
    end
    i = 0;
    while (i < rq.size() && rq[i] < en_start + 1) i++;
    while (i < rq.size()) begin
      cur = rq[i]; sum = 0; ovf = 0; hi = MAXV; done = 0; endc = 0;
      for (int k = 0; k < NWIN; k++) begin
        if (i + 1 < rq.size() && rq[i+1] - cur <= MAXV) begin
          endc = rq[i+1];
          hi   = first_fall(cur, endc - 1);
          sum += endc - cur;
          cur  = endc;
          i++;
        end else begin
          endc = cur + MAXV;
          if (endc >= L) done = 1;
          else begin
            hi  = first_fall(cur, endc);
            ovf = 1;
          end
          break;
        end
      end
      if (done || endc + 1 >= L) break;
      e.per  = ovf ? MAXV : sum / NWIN;
      e.hi   = hi;
      e.ovf  = ovf;
      e.pres = endc + 1;
      acc = -1;
      for (int c = endc + 1; c < L; c++)
        if (rdy_w[c]) begin
          acc = c;
          break;
        end
      e.acc = acc;
      exp_q.push_back(e);
      if (acc < 0) break;
      while (i < rq.size() && rq[i] < acc) i++;
    end
  endtask

  task automatic run_phase(input bit stop_by_reset);
    compute_model();
    in_phase = 1'b1;
    for (int c = 0; c < L; c++) begin
      @(posedge clk); #1;
      pc      = c;
      sig_in  = sig_w[c];
      ready   = rdy_w[c];
      meas_en = (c >= en_start);
    end
    @(posedge clk); #1;
    in_phase = 1'b0;
    pc       = L;
    sig_in   = 1'b0;
    ready    = 1'b0;
    if (stop_by_reset) reset_n = 1'b0;
    else meas_en = 1'b0;
    @(posedge clk); #1;
    check("valid_after_stop", int'(valid), 0);
    check("busy_after_stop", int'(busy), 0);
    if (stop_by_reset) begin
      check("period_in_reset", int'(period), 0);
      check("high_time_in_reset", int'(high_time), 0);
      check("overflow_in_reset", int'(overflow), 0);
      meas_en = 1'b0;
      reset_n = 1'b1;
    end
    while (exp_q.size() > 0 && exp_q[0].acc < 0) void'(exp_q.pop_front());
    check("results_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (8) @(posedge clk);
  endtask

  task automatic rand_phase(input int maxp, input int n);
    ph_hi.delete();
    ph_lo.delete();
    for (int j = 0; j < n; j++)
      add_period(int'($urandom_range(2, maxp)), int'($urandom_range(2, maxp)));
    build_wave(8);
    for (int c = 0; c < L - 20; c++) rdy_w[c] = ($urandom_range(0, 3) != 0);
    run_phase(1'b0);
  endtask

  // Scoreboard monitor: held result must match the head entry, accept pops it
  initial begin
    forever begin
      @(negedge clk);
      if (in_phase && valid) begin
        if (exp_q.size() == 0) check("unexpected_valid_cycle", pc, -1);
        else begin
          mon_e = exp_q[0];
          n_cmp++;
          if (int'(period) != mon_e.per || int'(high_time) != mon_e.hi ||
              overflow != mon_e.ovf || pc < mon_e.pres) begin
            n_bad++;
            $display("FAIL result at cycle %0d: period=%0d high_time=%0d overflow=%0b, required period=%0d high_time=%0d overflow=%0b from cycle %0d",
                     pc, period, high_time, overflow, mon_e.per, mon_e.hi, mon_e.ovf, mon_e.pres);
          end
          if (ready) begin
            check("accept_cycle", pc, mon_e.acc);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL timeout: bench did not complete within cycle budget");
    $fatal(1);
  end

  initial begin
    in_phase = 1'b0;
    pc       = 0;
    repeat (3) @(posedge clk); #1;
    check("reset_period", int'(period), 0);
    check("reset_high_time", int'(high_time), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Period 100, high 30, ready held
    set_periods(30, 70, 6);
    build_wave(8);
    run_phase(1'b0);

    // meas_en dropped while a window is open, then a clean run
    ph_hi.delete(); ph_lo.delete();
    add_period(30, 70); add_period(30, 70); add_period(30, 200);
    build_wave(8);
    run_phase(1'b0);
    set_periods(30, 70, 6);
    build_wave(8);
    run_phase(1'b0);

    // Saturation: no fall, exact full-scale period, one past full scale, fall seen
    ph_hi.delete(); ph_lo.delete();
    add_period(300, 10); add_period(100, 155); add_period(100, 156);
    add_period(20, 400); add_period(30, 70); add_period(30, 70);
    build_wave(8);
    run_phase(1'b0);

    // Consumer stall with a single accept pulse mid-stream
    set_periods(20, 30, 8);
    build_wave(8);
    for (int c = 0; c < L - 20; c++) rdy_w[c] = 1'b0;
    rdy_w[8 + LAT + 50 * 3 + 10] = 1'b1;
    run_phase(1'b0);

    // Result left unaccepted, reset pulsed while holding, then a clean run
    set_periods(20, 30, 8);
    build_wave(8);
    for (int c = 0; c < L; c++) rdy_w[c] = 1'b0;
    run_phase(1'b1);
    set_periods(30, 70, 6);
    build_wave(8);
    run_phase(1'b0);

    // Accept exactly on each synchronized rise
    set_periods(15, 25, 8);
    build_wave(8);
    for (int c = 0; c < L - 20; c++) begin
      rdy_w[c] = 1'b0;
      if (c >= LAT && sig_w[c-LAT] && (c == LAT || !sig_w[c-LAT-1])) rdy_w[c] = 1'b1;
    end
    run_phase(1'b0);

    // Enable arrives while the input is already high
    set_periods(30, 70, 3);
    build_wave(60);
    for (int c = 0; c < 40; c++) sig_w[c] = 1'b1;
    en_start = 10;
    run_phase(1'b0);

    // Periods 100, 102, 98, 101 then steady 100
    ph_hi.delete(); ph_lo.delete();
    add_period(40, 60); add_period(40, 62); add_period(40, 58);
    add_period(40, 61); add_period(40, 60); add_period(40, 60);
    build_wave(8);
    run_phase(1'b0);

    rand_phase(60, 25);
    rand_phase(180, 25);
    rand_phase(8, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
